// File: rtl/mdio_link_poller.sv
// -----------------------------------------------------------------------------
// mdio_link_poller
//
// Clause 22 MDIO master with two clients:
//   * a host command port (one read or write frame per accepted command), and
//   * a periodic link poller that reads BMSR (register 1) of four PHYs in
//     round-robin order and keeps one link status bit per port.
// A host command that is waiting wins over a pending poll. The poll is never
// dropped; it runs after the host frame.
//
// Ports
//   clk_125m   : sole clock, all logic on the rising edge
//   resetn     : synchronous active-low reset
//   mdc        : free-running management clock (half-period = MDC_DIV clk)
//   mdio_o     : MDIO output data (changes on the mdc 1->0 cycle)
//   mdio_t     : MDIO tristate enable, 1 = released
//   mdio_i     : MDIO input data (sampled on the mdc 0->1 cycle)
//   poll_en    : enables periodic link polling
//   cmd_valid  : host request, held until cmd_ready
//   cmd_ready  : one-cycle accept pulse, high in the first clk of the frame
//   cmd_write  : 1 = write frame, 0 = read frame
//   cmd_phy    : PHY address
//   cmd_reg    : register address
//   cmd_wdata  : write data
//   rsp_valid  : one-cycle completion pulse for host frames
//   rsp_rdata  : read data (0 after a write), held until the next rsp_valid
//   link_up    : per-port link status from the last BMSR poll
// -----------------------------------------------------------------------------
module mdio_link_poller #(
  parameter int unsigned MDC_DIV       = 25,
  parameter logic [4:0]  PHY_ADDR_BASE = 5'd0,
  parameter int unsigned POLL_INTERVAL = 125000
) (
  input  logic        clk_125m,
  input  logic        resetn,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i,
  input  logic        poll_en,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [3:0]  link_up
);

  localparam int DIV_W  = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;
  localparam int POLL_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE} state_t;

  // Everything after the preamble, MSB first: ST, OP, PHYAD, REGAD, TA, DATA.
  // Reads carry all-ones in TA/DATA; those bits are never driven (mdio_t=1).
  function automatic logic [31:0] frame_word(input logic wr, input logic [4:0] phy,
                                             input logic [4:0] regad, input logic [15:0] wdata);
    return {2'b01, (wr ? 2'b01 : 2'b10), phy, regad, (wr ? 2'b10 : 2'b11),
            (wr ? wdata : 16'hFFFF)};
  endfunction

  logic [DIV_W-1:0]  div_cnt_reg;
  logic              mdc_reg;
  logic [POLL_W-1:0] poll_cnt_reg;
  logic              poll_pending_reg;
  state_t            state_reg;
  logic [5:0]        bit_cnt_reg;
  logic [31:0]       tx_reg;
  logic [15:0]       rx_reg;
  logic              is_read_reg;
  logic              is_poll_reg;
  logic [1:0]        port_idx_reg;
  logic              mdio_o_reg;
  logic              mdio_t_reg;
  logic              cmd_ready_reg;
  logic              rsp_valid_reg;
  logic [15:0]       rsp_rdata_reg;
  logic [3:0]        link_up_reg;

  logic       div_wrap;
  logic       mdc_fall;
  logic       mdc_rise;
  logic       poll_wrap;
  logic       start_host;
  logic       start_poll;
  logic [5:0] bit_cnt_next;
  logic [4:0] poll_phy;

  assign div_wrap     = (div_cnt_reg == DIV_W'(MDC_DIV - 1));
  assign mdc_fall     = div_wrap & mdc_reg;
  assign mdc_rise     = div_wrap & ~mdc_reg;
  assign poll_wrap    = (poll_cnt_reg == POLL_W'(POLL_INTERVAL - 1));
  assign start_host   = (state_reg == S_IDLE) & mdc_fall & cmd_valid;
  assign start_poll   = (state_reg == S_IDLE) & mdc_fall & ~cmd_valid & poll_pending_reg & poll_en;
  assign bit_cnt_next = bit_cnt_reg + 6'd1;
  assign poll_phy     = PHY_ADDR_BASE + {3'b000, port_idx_reg};

  // Free-running MDC divider.
  always_ff @(posedge clk_125m) begin
    if (!resetn) begin
      div_cnt_reg <= '0;
      mdc_reg     <= 1'b0;
    end else if (div_wrap) begin
      div_cnt_reg <= '0;
      mdc_reg     <= ~mdc_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + DIV_W'(1);
    end
  end

  // Poll timer and pending flag. Starting a poll consumes the flag even when
  // the timer wraps on the same cycle, so a wrap never queues a second poll.
  always_ff @(posedge clk_125m) begin
    if (!resetn) begin
      poll_cnt_reg     <= '0;
      poll_pending_reg <= 1'b0;
    end else begin
      poll_cnt_reg <= poll_wrap ? '0 : poll_cnt_reg + POLL_W'(1);
      if (!poll_en || start_poll) begin
        poll_pending_reg <= 1'b0;
      end else if (poll_wrap) begin
        poll_pending_reg <= 1'b1;
      end
    end
  end

  // Frame sequencer. bit_cnt_reg is the index (0..63) of the bit on the bus.
  always_ff @(posedge clk_125m) begin
    if (!resetn) begin
      state_reg     <= S_IDLE;
      bit_cnt_reg   <= '0;
      tx_reg        <= '0;
      rx_reg        <= '0;
      is_read_reg   <= 1'b0;
      is_poll_reg   <= 1'b0;
      port_idx_reg  <= '0;
      mdio_o_reg    <= 1'b1;
      mdio_t_reg    <= 1'b1;
      cmd_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      link_up_reg   <= '0;
    end else begin
      cmd_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      if (mdc_rise && state_reg == S_DATA) begin
        rx_reg <= {rx_reg[14:0], mdio_i};
      end
      case (state_reg)
        S_IDLE: begin
          mdio_o_reg <= 1'b1;
          mdio_t_reg <= 1'b1;
          if (start_host || start_poll) begin
            state_reg     <= S_PRE;
            bit_cnt_reg   <= '0;
            mdio_t_reg    <= 1'b0;
            is_poll_reg   <= start_poll;
            is_read_reg   <= start_poll | ~cmd_write;
            cmd_ready_reg <= start_host;
            tx_reg        <= start_host ? frame_word(cmd_write, cmd_phy, cmd_reg, cmd_wdata)
                                        : frame_word(1'b0, poll_phy, 5'd1, 16'hFFFF);
          end
        end
        S_PRE, S_HDR, S_TA, S_DATA: begin
          if (mdc_fall) begin
            if (bit_cnt_reg == 6'd63) begin
              state_reg  <= S_DONE;
              mdio_o_reg <= 1'b1;
              mdio_t_reg <= 1'b1;
              if (is_poll_reg) begin
                // All-ones BMSR means nothing answered: report link down.
                link_up_reg[port_idx_reg] <= (rx_reg == 16'hFFFF) ? 1'b0 : rx_reg[2];
                port_idx_reg <= port_idx_reg + 2'd1;
              end else begin
                rsp_valid_reg <= 1'b1;
                rsp_rdata_reg <= is_read_reg ? rx_reg : 16'h0000;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_next;
              if (bit_cnt_next < 6'd32) begin
                mdio_o_reg <= 1'b1;
              end else begin
                mdio_o_reg <= tx_reg[31];
                tx_reg     <= {tx_reg[30:0], 1'b0};
                // Reads hand the bus to the PHY from the first TA bit onward.
                mdio_t_reg <= is_read_reg & (bit_cnt_next >= 6'd46);
                if (bit_cnt_next < 6'd46) begin
                  state_reg <= S_HDR;
                end else if (bit_cnt_next < 6'd48) begin
                  state_reg <= S_TA;
                end else begin
                  state_reg <= S_DATA;
                end
              end
            end
          end
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign mdc       = mdc_reg;
  assign mdio_o    = mdio_o_reg;
  assign mdio_t    = mdio_t_reg;
  assign cmd_ready = cmd_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign link_up   = link_up_reg;

endmodule

// File: tb/tb_mdio_link_poller.sv
// -----------------------------------------------------------------------------
// tb_mdio_link_poller
//
// Bench for mdio_link_poller. A frame-level model watches the bus at every
// negative clock edge: it collects the 64 bits of each frame, plays a PHY that
// answers reads, and derives the expected rsp_rdata / link_up from the decoded
// frames. Directed sequences cover host read/write, the four-port poll, host
// priority over a pending poll, dropping poll_en mid-poll and reset mid-frame.
// -----------------------------------------------------------------------------
module tb_mdio_link_poller;

  localparam int         MDC_DIV  = 2;
  localparam int         POLL_INT = 200;
  localparam logic [4:0] BASE     = 5'd0;

  logic        bd_fclk0_125m;
  logic        resetn;
  logic        mdc;
  logic        mdio_o;
  logic        mdio_t;
  logic        mdio_i;
  logic        poll_en;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_phy;
  logic [4:0]  cmd_reg;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [3:0]  link_up;

  mdio_link_poller #(
    .MDC_DIV      (MDC_DIV),
    .PHY_ADDR_BASE(BASE),
    .POLL_INTERVAL(POLL_INT)
  ) dut (
    .clk_125m (bd_fclk0_125m),
    .resetn   (resetn),
    .mdc      (mdc),
    .mdio_o   (mdio_o),
    .mdio_t   (mdio_t),
    .mdio_i   (mdio_i),
    .poll_en  (poll_en),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_phy  (cmd_phy),
    .cmd_reg  (cmd_reg),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .link_up  (link_up)
  );

  initial bd_fclk0_125m = 1'b0;
  always #5 bd_fclk0_125m = ~bd_fclk0_125m;

  int errors = 0;
  int checks = 0;

  // PHY register contents
  logic [15:0] bmsr [4];

  // Model state
  int          rst_age = 0;
  logic        prev_mdc = 1'b0;
  bit          mdc_valid = 0;
  int          mdc_hold = 0;
  bit          in_frame = 0;
  int          pos = 0;
  logic [63:0] cur_bits, cur_t, last_bits, last_t;
  bit          cur_host = 0;
  logic [1:0]  cur_op;
  logic [4:0]  cur_phy, cur_reg, last_poll_phy;
  logic [15:0] cur_val;
  bit          host_next = 0;
  logic        h_write;
  logic [4:0]  h_phy, h_reg;
  logic [15:0] h_wdata;
  bit          rsp_pend = 0;
  int          rsp_age = 0;
  logic [15:0] rsp_exp;
  bit          link_pend = 0;
  int          link_age = 0;
  logic [3:0]  link_exp = 4'h0;
  logic [3:0]  link_new;
  int          poll_port = 0;
  int          poll_count = 0;
  int          frame_total = 0;
  int          host_fno = 0;
  int          poll_fno [32];
  int          ready_count = 0;
  int          rsp_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] phy_val(input logic [4:0] p, input logic [4:0] r);
    if (r == 5'd1 && p < 5'd4) return bmsr[p[1:0]];
    if (p == 5'd3 && r == 5'd2) return 16'h0141;
    return 16'hFFFF;
  endfunction

  task automatic finish_frame();
    logic [4:0] pp;
    in_frame  = 0;
    frame_total++;
    last_bits = cur_bits;
    last_t    = cur_t;
    chk("preamble_st", 64'(cur_bits[63:30]), 64'({32'hFFFF_FFFF, 2'b01}));
    chk("mdio_t_pattern", cur_t, (cur_op == 2'b10) ? 64'h3FFFF : 64'h0);
    if (cur_host) begin
      chk("host_hdr", 64'({cur_op, cur_phy, cur_reg}),
          64'({(h_write ? 2'b01 : 2'b10), h_phy, h_reg}));
      if (h_write) chk("host_wr_ta_data", 64'(cur_bits[17:0]), 64'({2'b10, h_wdata}));
      rsp_pend = 1;
      rsp_age  = 0;
      rsp_exp  = h_write ? 16'h0000 : cur_val;
      host_fno = frame_total;
    end else begin
      pp = BASE + 5'(poll_port);
      chk("poll_hdr", 64'({cur_op, cur_phy, cur_reg}), 64'({2'b10, pp, 5'd1}));
      link_new = link_exp;
      link_new[poll_port] = (cur_val == 16'hFFFF) ? 1'b0 : cur_val[2];
      link_pend = 1;
      link_age  = 0;
      poll_port = (poll_port + 1) % 4;
      poll_count++;
      if (poll_count < 32) poll_fno[poll_count] = frame_total;
      last_poll_phy = cur_phy;
    end
  endtask

  task automatic model_step();
    if (!resetn) begin
      rst_age++;
      if (rst_age >= 2)
        chk("reset_outputs", 64'({mdc, mdio_o, mdio_t, cmd_ready, rsp_valid, rsp_rdata, link_up}),
            64'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0}));
      in_frame = 0; pos = 0; rsp_pend = 0; link_pend = 0; link_exp = 4'h0;
      poll_port = 0; host_next = 0; prev_mdc = 1'b0; mdc_valid = 0; mdc_hold = 0;
      mdio_i = 1'b1;
      return;
    end
    rst_age = 0;

    if (mdc !== prev_mdc) begin
      if (mdc_valid) chk("mdc_half_period", 64'(mdc_hold), 64'(MDC_DIV));
      mdc_valid = 1;
      mdc_hold  = 1;
    end else begin
      mdc_hold++;
    end

    if (cmd_ready) begin
      chk("cmd_ready_at_start", 64'({cmd_valid, in_frame, mdio_t}), 64'(3'b100));
      host_next = 1;
      h_write = cmd_write; h_phy = cmd_phy; h_reg = cmd_reg; h_wdata = cmd_wdata;
      ready_count++;
    end

    if (rsp_valid) begin
      chk("rsp_expected", 64'(rsp_pend), 64'd1);
      if (rsp_pend) chk("rsp_rdata", 64'(rsp_rdata), 64'(rsp_exp));
      rsp_pend = 0;
      rsp_count++;
    end else if (rsp_pend) begin
      rsp_age++;
      if (rsp_age > 2 * MDC_DIV + 4) begin
        chk("rsp_timeout", 64'd0, 64'd1);
        rsp_pend = 0;
      end
    end

    if (link_pend) begin
      if (link_up === link_new) begin
        chk("link_update", 64'(link_up), 64'(link_new));
        link_exp = link_new; link_pend = 0;
      end else if (link_age > 2 * MDC_DIV + 4) begin
        chk("link_update", 64'(link_up), 64'(link_new));
        link_exp = link_new; link_pend = 0;
      end else begin
        link_age++;
        chk("link_hold", 64'(link_up), 64'(link_exp));
      end
    end else begin
      chk("link_up", 64'(link_up), 64'(link_exp));
    end

    if (!in_frame && !rsp_pend && !link_pend && mdio_t)
      chk("idle_mdio_o", 64'(mdio_o), 64'd1);

    if (mdc && !prev_mdc) begin
      if (!in_frame && !mdio_t) begin
        in_frame = 1; pos = 0; cur_bits = '0; cur_t = '0;
        cur_host = host_next; host_next = 0; cur_op = 2'b00;
      end
      if (in_frame) begin
        cur_bits = {cur_bits[62:0], mdio_o};
        cur_t    = {cur_t[62:0], mdio_t};
        pos++;
        if (pos == 46) begin
          cur_op  = cur_bits[11:10];
          cur_phy = cur_bits[9:5];
          cur_reg = cur_bits[4:0];
          cur_val = phy_val(cur_phy, cur_reg);
        end
        if (pos == 64) finish_frame();
      end
    end

    // PHY side: present read data after the falling edge preceding its rise
    if (!mdc && prev_mdc) begin
      mdio_i = 1'b1;
      if (in_frame && pos >= 48 && pos <= 63 && cur_op == 2'b10) mdio_i = cur_val[63 - pos];
    end
    prev_mdc = mdc;
  endtask

  task automatic tick();
    @(negedge bd_fclk0_125m);
    model_step();
    @(posedge bd_fclk0_125m);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [4:0] p, input logic [4:0] r,
                       input logic [15:0] d);
    int n0;
    cmd_write = wr; cmd_phy = p; cmd_reg = r; cmd_wdata = d; cmd_valid = 1'b1;
    n0 = ready_count;
    for (int i = 0; i < 3000 && ready_count == n0; i++) tick();
    if (ready_count == n0) chk("cmd_ready_timeout", 64'd0, 64'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n0);
    for (int i = 0; i < 3000 && rsp_count == n0; i++) tick();
    if (rsp_count == n0) chk("rsp_wait_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_polls(input int n);
    for (int i = 0; i < 8000 && !(poll_count >= n && !link_pend); i++) tick();
    chk("poll_count_reached", 64'(poll_count >= n), 64'd1);
  endtask

  initial begin
    int n0, f0;
    bmsr[0] = 16'h796D; bmsr[1] = 16'h7969; bmsr[2] = 16'hFFFF; bmsr[3] = 16'h796D;
    resetn = 1'b0; mdio_i = 1'b1; poll_en = 1'b0; cmd_valid = 1'b0;
    cmd_write = 1'b0; cmd_phy = '0; cmd_reg = '0; cmd_wdata = '0;
    for (int i = 0; i < 4; i++) tick();
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) tick();

    // Host read phy 3 reg 2
    n0 = rsp_count;
    issue(1'b0, 5'd3, 5'd2, 16'h0000);
    wait_rsp(n0);
    chk("rd_rdata", 64'(rsp_rdata), 64'h0141);
    chk("rd_hdr_bits", 64'(last_bits[63:18]), 64'({32'hFFFF_FFFF, 14'b01_10_00011_00010}));
    chk("rd_t_bits", last_t, 64'h3FFFF);
    for (int i = 0; i < 40; i++) tick();
    chk("rd_single_rsp", 64'(rsp_count - n0), 64'd1);

    // Host write phy 1 reg 0 data 1140
    n0 = rsp_count;
    issue(1'b1, 5'd1, 5'd0, 16'h1140);
    wait_rsp(n0);
    chk("wr_bits", last_bits,
        {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h1140});
    chk("wr_t_bits", last_t, 64'h0);
    chk("wr_rdata", 64'(rsp_rdata), 64'h0);

    // Four polls
    poll_en = 1'b1;
    wait_polls(4);
    chk("link_after_4_polls", 64'(link_up), 64'(4'b1001));

    // Fifth poll in flight: raise a host command while a poll is pending
    for (int i = 0; i < 2000 && !(in_frame && !cur_host && pos >= 46); i++) tick();
    chk("poll5_phy", 64'(cur_phy), 64'd0);
    n0 = rsp_count;
    issue(1'b0, 5'd3, 5'd2, 16'h0000);
    wait_rsp(n0);
    chk("prio_rdata", 64'(rsp_rdata), 64'h0141);
    wait_polls(6);
    chk("host_after_poll5", 64'(host_fno), 64'(poll_fno[5] + 1));
    chk("poll6_after_host", 64'(poll_fno[6]), 64'(host_fno + 1));
    chk("poll6_phy", 64'(last_poll_phy), 64'd1);

    // Drop poll_en mid-poll after changing the PHYs' link bits
    for (int i = 0; i < 2000 && !(in_frame && !cur_host && pos >= 5 && pos <= 30); i++) tick();
    bmsr[0] = 16'h7969; bmsr[1] = 16'h796D; bmsr[2] = 16'h796D; bmsr[3] = 16'h7969;
    poll_en = 1'b0;
    n0 = poll_count;
    for (int i = 0; i < 1000 && (in_frame || link_pend); i++) tick();
    chk("inflight_poll_done", 64'(poll_count - n0), 64'd1);
    f0 = frame_total;
    for (int i = 0; i < 3 * POLL_INT; i++) tick();
    chk("no_poll_when_disabled", 64'(frame_total), 64'(f0));

    // Reset during the data phase of a host read
    n0 = rsp_count;
    issue(1'b0, 5'd3, 5'd2, 16'h0000);
    for (int i = 0; i < 2000 && !(in_frame && cur_host && pos >= 50); i++) tick();
    chk("reached_data_phase", 64'(pos >= 50), 64'd1);
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    chk("no_rsp_after_abort", 64'(rsp_count), 64'(n0));
    n0 = rsp_count;
    issue(1'b0, 5'd3, 5'd2, 16'h0000);
    wait_rsp(n0);
    chk("post_reset_rdata", 64'(rsp_rdata), 64'h0141);
    chk("post_reset_link", 64'(link_up), 64'h0);
    for (int i = 0; i < 20; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
